uart_loader: RTL and testbench

- Hardware boot loader and initiator for the uart register interface. It replaces the CPU as master on the uart's 4-bit io bus.
- Polls the uart, parses a byte-oriented load/go packet protocol, and writes payload bytes to memory through a ready-handshaked byte port.
- Answers each packet with ACK or NAK over uart TX, and starts the CPU with a one-cycle go pulse.

---
 rtl/uart_loader_pkg.sv | 46 ++++
 rtl/uart_loader.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_uart_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared types and constants for the uart boot loader.
//   - state_e : main FSM states (bus sequencing)
//   - phase_e : packet parser phases
//   - uart register addresses, status bit indices, default protocol bytes
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_POLL,
    ST_READ,
    ST_MEM,
    ST_TX,
    ST_TXWAIT,
    ST_TXCLR,
    ST_GO
  } state_e;

  typedef enum logic [2:0] {
    PH_SYNC,
    PH_AHI,
    PH_ALO,
    PH_LEN,
    PH_DATA,
    PH_CSUM,
    PH_GHI,
    PH_GLO
  } phase_e;

  // uart register map
  localparam logic [3:0] REG_RX     = 4'd0;
  localparam logic [3:0] REG_TX     = 4'd1;
  localparam logic [3:0] REG_STATUS = 4'd2;

  // status register bit positions
  localparam int RX_INT = 1;
  localparam int TX_INT = 0;

  // protocol defaults
  localparam logic [7:0] DEF_SYNC_LOAD = 8'hA5;
  localparam logic [7:0] DEF_SYNC_GO   = 8'h5A;
  localparam logic [7:0] DEF_ACK       = 8'h06;
  localparam logic [7:0] DEF_NAK       = 8'h15;

  // value written to status to clear the tx interrupt
  localparam logic [7:0] TX_INT_CLR = 8'h01;

endpackage

// File: rtl/uart_loader.sv
// uart_loader: boot loader acting as master on the uart 4-bit register bus.
// Polls the uart status, parses load (A5 AHI ALO LEN DATA.. CSUM) and go
// (5A GHI GLO CSUM) packets, writes payload bytes through a ready-handshaked
// byte port, answers ACK/NAK over uart TX and pulses go on a good go packet.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   enable              loader active (sampled in POLL only)
//   u_addr/u_wdata/u_write/u_read/u_rdata   uart register bus (u_rdata is
//                       combinational, valid in the cycle u_read is high)
//   mem_addr/mem_wdata/mem_write/mem_ready  byte write port
//   busy                packet in progress
//   csum_err, timeout, go   one-cycle pulses
//   go_addr             entry address, held until the next go
//
// Handshake: a memory write is presented by holding mem_write, mem_addr and
// mem_wdata stable; it completes on the first cycle where mem_write and
// mem_ready are both high.
//
// Optional: define UART_LOADER_TIMEOUT_EN to build the inter-byte timeout
// (parameter TIMEOUT, in clk cycles). Without it, timeout is tied to 0.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int         AW        = 16,
  parameter logic [7:0] SYNC_LOAD = DEF_SYNC_LOAD,
  parameter logic [7:0] SYNC_GO   = DEF_SYNC_GO,
  parameter logic [7:0] ACK       = DEF_ACK,
  parameter logic [7:0] NAK       = DEF_NAK
`ifdef UART_LOADER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 2000000
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic [3:0]    u_addr,
  output logic [7:0]    u_wdata,
  output logic          u_write,
  output logic          u_read,
  input  logic [7:0]    u_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_write,
  input  logic          mem_ready,
  output logic          busy,
  output logic          csum_err,
  output logic          timeout,
  output logic          go,
  output logic [AW-1:0] go_addr
);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic          is_go_q, is_go_d;
  logic          go_pend_q, go_pend_d;
  logic          ack_q, ack_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    hi_q, hi_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] ent_q, ent_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic [AW-1:0] go_addr_q, go_addr_d;
  logic          csum_err_q, csum_err_d;
  logic          go_q, go_d;
  // bus outputs are registered: they are decoded from the next state
  logic          u_read_q, u_read_d;
  logic          u_write_q, u_write_d;
  logic [3:0]    u_addr_q, u_addr_d;
  logic [7:0]    u_wdata_q, u_wdata_d;
  logic          mem_write_q, mem_write_d;
  logic [7:0]    csum_sum;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
`endif

  // running sum including the byte currently on u_rdata
  assign csum_sum = csum_q + u_rdata;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    is_go_d     = is_go_q;
    go_pend_d   = go_pend_q;
    ack_d       = ack_q;
    csum_d      = csum_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    ent_d       = ent_q;
    mem_wdata_d = mem_wdata_q;
    csum_err_d  = 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
    tmo_d       = tmo_q;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      ST_POLL: begin
`ifdef UART_LOADER_TIMEOUT_EN
        if (phase_q != PH_SYNC) begin
          if (tmo_q <= TW'(1)) begin
            timeout_d = 1'b1;
            phase_d   = PH_SYNC;
            tmo_d     = '0;
          end else begin
            tmo_d = tmo_q - TW'(1);
          end
        end
`endif
        if (!enable) begin
          phase_d = PH_SYNC;
        end else if (u_read_q && u_rdata[RX_INT]) begin
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        state_d = ST_POLL;
        csum_d  = csum_sum;
`ifdef UART_LOADER_TIMEOUT_EN
        tmo_d   = TW'(TIMEOUT);
`endif
        case (phase_q)
          PH_SYNC: begin
            csum_d = 8'h00;
            if (u_rdata == SYNC_LOAD) begin
              phase_d = PH_AHI;
              is_go_d = 1'b0;
            end else if (u_rdata == SYNC_GO) begin
              phase_d = PH_GHI;
              is_go_d = 1'b1;
            end
          end
          PH_AHI: begin
            hi_d    = u_rdata;
            phase_d = PH_ALO;
          end
          PH_ALO: begin
            addr_d  = AW'({hi_q, u_rdata});
            phase_d = PH_LEN;
          end
          PH_LEN: begin
            // a length byte of 0 encodes 256
            cnt_d   = (u_rdata == 8'h00) ? 9'd256 : {1'b0, u_rdata};
            phase_d = PH_DATA;
          end
          PH_DATA: begin
            mem_wdata_d = u_rdata;
            state_d     = ST_MEM;
          end
          PH_CSUM: begin
            ack_d      = (csum_sum == 8'h00);
            csum_err_d = (csum_sum != 8'h00);
            go_pend_d  = is_go_q && (csum_sum == 8'h00);
            phase_d    = PH_SYNC;
            state_d    = ST_TX;
          end
          PH_GHI: begin
            hi_d    = u_rdata;
            phase_d = PH_GLO;
          end
          PH_GLO: begin
            ent_d   = AW'({hi_q, u_rdata});
            phase_d = PH_CSUM;
          end
          default: phase_d = PH_SYNC;
        endcase
      end

      ST_MEM: begin
        if (mem_ready) begin
          addr_d  = addr_q + AW'(1);
          cnt_d   = cnt_q - 9'd1;
          state_d = ST_POLL;
          if (cnt_q == 9'd1) phase_d = PH_CSUM;
        end
      end

      ST_TX:     state_d = ST_TXWAIT;

      ST_TXWAIT: if (u_read_q && u_rdata[TX_INT]) state_d = ST_TXCLR;

      ST_TXCLR:  state_d = go_pend_q ? ST_GO : ST_POLL;

      ST_GO: begin
        go_pend_d = 1'b0;
        state_d   = ST_POLL;
      end

      default:   state_d = ST_POLL;
    endcase

    // Output decode from the next state so every output comes from a flop.
    u_read_d    = ((state_d == ST_POLL) && enable) ||
                  (state_d == ST_READ) || (state_d == ST_TXWAIT);
    u_write_d   = (state_d == ST_TX) || (state_d == ST_TXCLR);
    u_addr_d    = 4'd0;
    u_wdata_d   = 8'h00;
    case (state_d)
      ST_POLL:   u_addr_d = enable ? REG_STATUS : 4'd0;
      ST_READ:   u_addr_d = REG_RX;
      ST_TX: begin
        u_addr_d  = REG_TX;
        u_wdata_d = ack_d ? ACK : NAK;
      end
      ST_TXWAIT: u_addr_d = REG_STATUS;
      ST_TXCLR: begin
        u_addr_d  = REG_STATUS;
        u_wdata_d = TX_INT_CLR;
      end
      default:   u_addr_d = 4'd0;
    endcase
    mem_write_d = (state_d == ST_MEM);
    go_d        = (state_d == ST_GO);
    go_addr_d   = (state_d == ST_GO) ? ent_q : go_addr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_POLL;
      phase_q     <= PH_SYNC;
      is_go_q     <= 1'b0;
      go_pend_q   <= 1'b0;
      ack_q       <= 1'b0;
      csum_q      <= 8'h00;
      hi_q        <= 8'h00;
      cnt_q       <= 9'd0;
      addr_q      <= '0;
      ent_q       <= '0;
      mem_wdata_q <= 8'h00;
      go_addr_q   <= '0;
      csum_err_q  <= 1'b0;
      go_q        <= 1'b0;
      u_read_q    <= 1'b0;
      u_write_q   <= 1'b0;
      u_addr_q    <= 4'd0;
      u_wdata_q   <= 8'h00;
      mem_write_q <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      is_go_q     <= is_go_d;
      go_pend_q   <= go_pend_d;
      ack_q       <= ack_d;
      csum_q      <= csum_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      ent_q       <= ent_d;
      mem_wdata_q <= mem_wdata_d;
      go_addr_q   <= go_addr_d;
      csum_err_q  <= csum_err_d;
      go_q        <= go_d;
      u_read_q    <= u_read_d;
      u_write_q   <= u_write_d;
      u_addr_q    <= u_addr_d;
      u_wdata_q   <= u_wdata_d;
      mem_write_q <= mem_write_d;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_q       <= tmo_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign u_addr    = u_addr_q;
  assign u_wdata   = u_wdata_q;
  assign u_write   = u_write_q;
  assign u_read    = u_read_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;
  assign busy      = (phase_q != PH_SYNC);
  assign csum_err  = csum_err_q;
  assign go        = go_q;
  assign go_addr   = go_addr_q;
`ifdef UART_LOADER_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed bench for uart_loader with a uart/host responder,
// a memory responder with programmable stall, a packet-level model and a
// per-cycle compare process.
module tb_uart_loader;
  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [3:0]  u_addr;
  logic [7:0]  u_wdata;
  logic        u_write;
  logic        u_read;
  logic [7:0]  u_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic        mem_ready;
  logic        busy;
  logic        csum_err;
  logic        timeout;
  logic        go;
  logic [15:0] go_addr;

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_loader #(
    .AW(16)
`ifdef UART_LOADER_TIMEOUT_EN
    , .TIMEOUT(100)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .u_addr(u_addr), .u_wdata(u_wdata), .u_write(u_write), .u_read(u_read),
    .u_rdata(u_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_ready(mem_ready),
    .busy(busy), .csum_err(csum_err), .timeout(timeout),
    .go(go), .go_addr(go_addr)
  );

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- uart + host responder ----------------
  logic [7:0] host_buf [0:255];
  int         host_wr = 0;
  int         host_rd = 0;
  logic [7:0] rx_data;
  logic       rx_int, tx_int;
  int         tx_delay, gap;

  always_comb begin
    u_rdata = 8'h00;
    if (u_read) begin
      if (u_addr == 4'd0) u_rdata = rx_data;
      else if (u_addr == 4'd2) u_rdata = {6'b0, rx_int, tx_int};
    end
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      rx_data <= 8'h00; rx_int <= 1'b0; tx_int <= 1'b0; tx_delay <= 0; gap <= 0;
    end else begin
      if (gap > 0) gap <= gap - 1;
      if (u_read && u_addr == 4'd0) begin
        rx_int <= 1'b0;
        gap    <= 4;
      end else if (!rx_int && gap == 0 && host_rd < host_wr) begin
        rx_data <= host_buf[host_rd];
        rx_int  <= 1'b1;
        host_rd <= host_rd + 1;
      end
      if (u_write && u_addr == 4'd1) tx_delay <= 5;
      else if (tx_delay > 0) begin
        tx_delay <= tx_delay - 1;
        if (tx_delay == 1) tx_int <= 1'b1;
      end
      if (u_write && u_addr == 4'd2 && u_wdata[0]) tx_int <= 1'b0;
    end
  end

  // ---------------- memory responder ----------------
  int stall_cycles = 0;
  int hold_cnt = 0;
  assign mem_ready = (hold_cnt >= stall_cycles);
  always @(posedge clk) begin
    if (mem_write && !mem_ready) hold_cnt <= hold_cnt + 1;
    else hold_cnt <= 0;
  end

  // ---------------- scoreboard ----------------
  logic [23:0] exp_mem_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [15:0] exp_go_q[$];
  int          exp_err = 0;

  logic [7:0]  mem_seen [int];
  int          mem_wr_cnt = 0, tx_seen = 0, go_seen = 0, err_seen = 0;
  int          tmo_seen = 0, stall_seen = 0;
  logic [7:0]  last_tx = 8'h00;
  logic [15:0] last_go_exp = 16'h0000;
  logic        prev_stall = 1'b0, prev_txclr = 1'b0, prev_go = 1'b0, prev_err = 1'b0;
  logic [15:0] p_addr;
  logic [7:0]  p_data;

  always @(negedge clk) begin
    if (reset_n) begin
      check(!(u_read && u_write), "bus_one_strobe", {u_read, u_write}, 0);
      if (!u_read && !u_write)
        check(u_addr == 4'd0 && u_wdata == 8'h00, "bus_idle_zero", {u_addr, u_wdata}, 0);
      if (prev_stall)
        check(mem_write && mem_addr == p_addr && mem_wdata == p_data, "stall_stable",
              {mem_write, mem_addr, mem_wdata}, {1'b1, p_addr, p_data});
      if (mem_write) begin
        check(!u_read && !u_write, "no_uart_in_mem", {u_read, u_write}, 0);
        if (!mem_ready) stall_seen++;
      end
      if (mem_write && mem_ready) begin
        mem_wr_cnt++;
        mem_seen[int'(mem_addr)] = mem_wdata;
        if (exp_mem_q.size() == 0) check(0, "mem_unexpected", {mem_addr, mem_wdata}, 0);
        else begin
          logic [23:0] e;
          e = exp_mem_q.pop_front();
          check({mem_addr, mem_wdata} == e, "mem_write", {mem_addr, mem_wdata}, e);
        end
      end
      if (u_write && u_addr == 4'd1) begin
        tx_seen++;
        last_tx = u_wdata;
        if (exp_tx_q.size() == 0) check(0, "tx_unexpected", u_wdata, 0);
        else begin
          logic [7:0] e;
          e = exp_tx_q.pop_front();
          check(u_wdata == e, "tx_byte", u_wdata, e);
        end
      end
      if (csum_err) begin
        err_seen++;
        check(!prev_err, "csum_err_one_cycle", 1, 0);
      end
      if (timeout) tmo_seen++;
      if (go) begin
        go_seen++;
        check(prev_txclr, "go_after_txclr", prev_txclr, 1);
        check(!prev_go, "go_one_cycle", prev_go, 0);
        if (exp_go_q.size() == 0) check(0, "go_unexpected", go_addr, 0);
        else begin
          last_go_exp = exp_go_q.pop_front();
          check(go_addr == last_go_exp, "go_addr", go_addr, last_go_exp);
        end
      end else begin
        check(go_addr == last_go_exp, "go_addr_hold", go_addr, last_go_exp);
      end
      prev_stall = mem_write && !mem_ready;
      p_addr     = mem_addr;
      p_data     = mem_wdata;
      prev_txclr = u_write && u_addr == 4'd2 && u_wdata == 8'h01;
      prev_go    = go;
      prev_err   = csum_err;
    end
  end

  // Packet-level model: walks the host byte stream, skipping noise, and
  // derives the writes, responses and go addresses the loader must produce.
  task automatic model_stream(input byte_q_t s);
    int i, a, n, sum;
    logic [7:0] b;
    i = 0;
    while (i < s.size()) begin
      b = s[i];
      i++;
      if (b == 8'hA5) begin
        a   = {s[i], s[i+1]};
        n   = (s[i+2] == 8'h00) ? 256 : int'(s[i+2]);
        sum = s[i] + s[i+1] + s[i+2];
        for (int k = 0; k < n; k++) begin
          exp_mem_q.push_back({16'((a + k) % 65536), s[i+3+k]});
          sum += s[i+3+k];
        end
        sum += s[i+3+n];
        if (sum % 256 == 0) exp_tx_q.push_back(8'h06);
        else begin exp_tx_q.push_back(8'h15); exp_err++; end
        i += 4 + n;
      end else if (b == 8'h5A) begin
        a   = {s[i], s[i+1]};
        sum = s[i] + s[i+1] + s[i+2];
        if (sum % 256 == 0) begin
          exp_tx_q.push_back(8'h06);
          exp_go_q.push_back(16'(a));
        end else begin
          exp_tx_q.push_back(8'h15);
          exp_err++;
        end
        i += 3;
      end
    end
  endtask

  // driver: queue bytes to the host, optionally feeding the model
  task automatic send(input byte_q_t s, input bit use_model);
    if (use_model) model_stream(s);
    foreach (s[j]) begin
      host_buf[host_wr] = s[j];
      host_wr++;
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    bit done;
    done = 0;
    for (c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (host_rd == host_wr && !rx_int && exp_mem_q.size() == 0 &&
          exp_tx_q.size() == 0 && exp_go_q.size() == 0 && !busy) done = 1;
    end
    check(done, {"wait_", name}, c, 5000);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    check({u_addr, u_wdata, u_write, u_read, mem_addr, mem_wdata, mem_write,
           busy, csum_err, timeout, go, go_addr} == '0, "reset_outputs",
          {u_addr, u_wdata, u_write, u_read, mem_write, busy, go}, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (2) @(negedge clk);
    check(u_read && u_addr == 4'd2, "poll_status", {u_read, u_addr}, {1'b1, 4'd2});

    // load
    send('{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'hB9}, 1);
    wait_idle("load");
    check(mem_seen[32'h1234] == 8'hAA, "load_1234", mem_seen[32'h1234], 8'hAA);
    check(mem_seen[32'h1235] == 8'h55, "load_1235", mem_seen[32'h1235], 8'h55);
    check(last_tx == 8'h06, "load_ack", last_tx, 8'h06);
    check(err_seen == 0, "load_no_err", err_seen, 0);

    // bad checksum
    send('{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'hB8}, 1);
    wait_idle("bad");
    check(last_tx == 8'h15, "bad_nak", last_tx, 8'h15);
    check(err_seen == 1 && err_seen == exp_err, "bad_err_count", err_seen, 1);
    check(mem_wr_cnt == 4, "bad_mem_writes", mem_wr_cnt, 4);

    // noise and address wrap
    send('{8'h00, 8'hFF, 8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFD}, 1);
    wait_idle("wrap");
    check(mem_seen[32'hFFFF] == 8'h01, "wrap_ffff", mem_seen[32'hFFFF], 8'h01);
    check(mem_seen[32'h0000] == 8'h02, "wrap_0000", mem_seen[32'h0000], 8'h02);
    check(last_tx == 8'h06, "wrap_ack", last_tx, 8'h06);

    // go
    send('{8'h5A, 8'h40, 8'h00, 8'hC0}, 1);
    wait_idle("go");
    check(go_seen == 1, "go_count", go_seen, 1);
    check(go_addr == 16'h4000, "go_addr_lit", go_addr, 16'h4000);
    check(mem_wr_cnt == 6, "go_no_mem", mem_wr_cnt, 6);
    check(last_tx == 8'h06, "go_ack", last_tx, 8'h06);

    // memory stall on the data byte
    stall_cycles = 10;
    send('{8'hA5, 8'h20, 8'h00, 8'h01, 8'h77, 8'h68}, 1);
    wait_idle("stall");
    stall_cycles = 0;
    check(stall_seen == 10, "stall_cycles", stall_seen, 10);
    check(mem_seen[32'h2000] == 8'h77, "stall_data", mem_seen[32'h2000], 8'h77);

    // enable dropped mid-packet discards it
    send('{8'hA5, 8'h30}, 0);
    for (int c = 0; c < 200 && !(host_rd == host_wr && !rx_int && busy); c++) @(negedge clk);
    repeat (8) @(negedge clk);
    check(busy, "partial_busy", busy, 1);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check(!busy && !u_read, "disable_abort", {busy, u_read}, 0);
    enable = 1'b1;
    send('{8'hA5, 8'h30, 8'h00, 8'h01, 8'h11, 8'hBE}, 1);
    wait_idle("after_disable");
    check(mem_seen[32'h3000] == 8'h11, "reenable_data", mem_seen[32'h3000], 8'h11);

`ifdef UART_LOADER_TIMEOUT_EN
    begin
      int tx_before;
      tx_before = tx_seen;
      send('{8'hA5, 8'h12}, 0);
      repeat (150) @(negedge clk);
      check(tmo_seen == 1, "timeout_pulse", tmo_seen, 1);
      check(!busy, "timeout_idle", busy, 0);
      check(tx_seen == tx_before, "timeout_no_tx", tx_seen, tx_before);
      send('{8'hA5, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'hB9}, 1);
      wait_idle("post_timeout");
      check(last_tx == 8'h06, "post_timeout_ack", last_tx, 8'h06);
    end
`else
    check(tmo_seen == 0, "timeout_absent", tmo_seen, 0);
`endif

    check(exp_err == err_seen, "err_total", err_seen, exp_err);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
